// File: rtl/acumulador_mac.sv
// Sequential multiply-accumulate: TAPS signed N-bit products summed into a 2N-bit result,
// fetching one coefficient/sample pair per tap from a synchronous memory addressed by indice.
module acumulador_mac #(
  parameter int unsigned N    = 25,
  parameter int unsigned TAPS = 5,
  parameter int unsigned IW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N-1:0]    coef,
  input  logic [N-1:0]    dato,
  output logic [IW-1:0]   indice,
  output logic [2*N-1:0]  Datos_Sum,
  output logic            Ban_List,
  output logic            listo
);

  typedef enum logic [1:0] {StIdle, StLeer, StSumar, StFin} state_e;

  localparam logic [IW-1:0] LastTap = IW'(TAPS - 1);

  state_e               state_q;
  logic [2*N-1:0]       acc_q;
  logic signed [2*N-1:0] coef_ext;
  logic signed [2*N-1:0] dato_ext;
  logic signed [2*N-1:0] prod;

  // Operands are sign-extended first so the low 2N bits hold the exact signed product.
  always_comb begin
    coef_ext = {{N{coef[N-1]}}, coef};
    dato_ext = {{N{dato[N-1]}}, dato};
    prod     = coef_ext * dato_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      Datos_Sum <= '0;
      indice    <= '0;
      Ban_List  <= 1'b0;
      listo     <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            acc_q    <= '0;
            indice   <= '0;
            Ban_List <= 1'b1;
            state_q  <= StLeer;
          end
        end
        // Memory read latency: coef/dato for the new indice arrive next cycle.
        StLeer: state_q <= StSumar;
        StSumar: begin
          // Wraps modulo 2^(2N); saturation is the downstream stage's job.
          acc_q <= acc_q + prod;
          if (indice == LastTap) begin
            state_q <= StFin;
          end else begin
            indice  <= indice + IW'(1);
            state_q <= StLeer;
          end
        end
        StFin: begin
          Datos_Sum <= acc_q;
          Ban_List  <= 1'b0;
          listo     <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_acumulador_mac.sv
// Scoreboard bench for acumulador_mac: directed runs push expected sums, a monitor checks
// every listo pulse plus result hold, latency and busy/index sequencing.
module tb_acumulador_mac;

  localparam int N    = 25;
  localparam int TAPS = 5;
  localparam int IW   = 3;
  localparam int LAT  = 2 * TAPS + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [N-1:0]    coef;
  logic [N-1:0]    dato;
  logic [IW-1:0]   indice;
  logic [2*N-1:0]  Datos_Sum;
  logic            Ban_List;
  logic            listo;

  acumulador_mac #(.N(N), .TAPS(TAPS), .IW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .coef      (coef),
    .dato      (dato),
    .indice    (indice),
    .Datos_Sum (Datos_Sum),
    .Ban_List  (Ban_List),
    .listo     (listo)
  );

  always #5 clk = ~clk;

  // Synchronous operand memories: one cycle read latency.
  logic [N-1:0] coef_mem [8];
  logic [N-1:0] dato_mem [8];
  always @(posedge clk) begin
    coef <= coef_mem[indice];
    dato <= dato_mem[indice];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [2*N-1:0] sum;
    int             e0;
  } exp_t;
  exp_t q[$];

  int             n_cmp  = 0;
  int             n_fail = 0;
  logic [2*N-1:0] held_exp = '0;
  logic           prev_listo = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per listo pulse; between pulses the result must hold.
  always @(negedge clk) begin
    exp_t e;
    if (listo) begin
      check("listo_one_cycle", 64'(prev_listo), 64'(0));
      if (q.size() == 0) begin
        check("listo_unexpected", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        check("datos_sum", 64'(Datos_Sum), 64'(e.sum));
        check("latency", 64'(cyc - e.e0), 64'(LAT));
        check("ban_list_at_listo", 64'(Ban_List), 64'(0));
        held_exp = e.sum;
      end
    end else begin
      check("datos_sum_hold", 64'(Datos_Sum), 64'(held_exp));
    end
    prev_listo = listo;
  end

  task automatic set_mems(input logic [N-1:0] c, input logic [N-1:0] d);
    for (int i = 0; i < 8; i++) begin
      coef_mem[i] = c;
      dato_mem[i] = d;
    end
  endtask

  // One accumulation; optionally re-asserts start while busy (sampled at E4 and E10).
  task automatic run_acc(input logic [2*N-1:0] exp_sum, input bit busy_starts);
    @(negedge clk);
    start = 1'b1;
    q.push_back('{exp_sum, cyc + 1});
    for (int t = 0; t <= LAT; t++) begin
      @(negedge clk);
      start = busy_starts && (t == 3 || t == 9);
      check("indice_seq", 64'(indice), 64'((t / 2 > TAPS - 1) ? TAPS - 1 : t / 2));
      check("ban_list_seq", 64'(Ban_List), 64'(t < LAT));
    end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("idle_ban_list", 64'(Ban_List), 64'(0));
      check("idle_indice", 64'(indice), 64'(TAPS - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      coef_mem[i] = N'($urandom);
      dato_mem[i] = N'($urandom);
    end
    // Reset with random stimulus on start
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      check("rst_datos_sum", 64'(Datos_Sum), 64'(0));
      check("rst_ban_list", 64'(Ban_List), 64'(0));
      check("rst_listo", 64'(listo), 64'(0));
      check("rst_indice", 64'(indice), 64'(0));
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_ban_list", 64'(Ban_List), 64'(0));
      check("post_rst_listo", 64'(listo), 64'(0));
      check("post_rst_indice", 64'(indice), 64'(0));
    end

    // Unity: 5 x (1.0 * 1.0)
    set_mems(25'h0004000, 25'h0004000);
    run_acc(50'h0000050000000, 1'b0);

    // Signed: 5 x (-1.0 * 0.5)
    set_mems(25'h1FFC000, 25'h0002000);
    run_acc(50'h3FFFFD8000000, 1'b0);

    // Busy-start ignore
    set_mems(25'h0004000, 25'h0004000);
    run_acc(50'h0000050000000, 1'b1);

    // Mid-run reset after tap 2 is added at E6
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst_n    = 1'b0;
    held_exp = '0;
    #1;
    check("midrst_datos_sum", 64'(Datos_Sum), 64'(0));
    check("midrst_ban_list", 64'(Ban_List), 64'(0));
    check("midrst_listo", 64'(listo), 64'(0));
    check("midrst_indice", 64'(indice), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_acc(50'h0000050000000, 1'b0);

    // Wrap-around: 5 x 2^48 mod 2^50
    set_mems(25'h1000000, 25'h1000000);
    run_acc(50'h1000000000000, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/acumulador_mac.md
# acumulador_mac

Sequential multiply-accumulate stage that computes a TAPS-term dot product of signed fixed-point coefficients and samples, one tap at a time. It reads operands from an external synchronous memory by index. It delivers a 2N-bit sum (`Datos_Sum`) and a busy flag (`Ban_List`) directly to the downstream truncation/saturation stage. That stage holds its output while `Ban_List` is 1 and re-evaluates once it drops.

## Interface
- N, 25, operand width; two's complement Q10.14 (1 sign, 10 integer, 14 fraction bits)
- TAPS, 5, number of products per result; 2 ≤ TAPS ≤ 2^IW
- IW, 3, width of the operand index
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a new accumulation; sampled only in IDLE
- coef  in  N  coefficient for the current `indice`; valid one cycle after `indice` changes
- dato  in  N  sample for the current `indice`; same timing as `coef`
- indice  out  IW  operand address presented to coefficient and sample memories
- Datos_Sum  out  2N  last completed sum, two's complement Q20.28 in 2N bits
- Ban_List  out  1  1 while an accumulation is in progress; downstream holds while 1
- listo  out  1  one-cycle pulse when `Datos_Sum` is updated

## Operation
- States: IDLE, LEER, SUMAR, FIN. Internal accumulator `acc` is 2N bits.
- IDLE: `Ban_List`=0. If `start`=1: set `acc`←0, `indice`←0, `Ban_List`←1, and go to LEER. Otherwise hold.
- LEER: wait one cycle for memory read latency, then go to SUMAR. `indice` is stable.
- SUMAR: `acc` ← `acc` + sext(`coef`×`dato`).
  - Product is a signed N×N multiply, sign-extended to 2N bits.
  - Addition wraps modulo 2^(2N); there is no saturation here, because saturation belongs to the downstream stage.
  - If `indice` = TAPS−1, go to FIN. Otherwise `indice`←`indice`+1 and go to LEER.
- FIN: `Datos_Sum`←`acc`, `Ban_List`←0, `listo`←1 for this cycle only, then go to IDLE.
- `Datos_Sum` changes only in FIN and holds its value at all other times.
- `start` is ignored in LEER, SUMAR and FIN. It is not queued.
- `indice` keeps its last value (TAPS−1) in IDLE until the next `start`.

## Timing
- Reset (async, while `rst_n`=0): state=IDLE, `acc`=0, `Datos_Sum`=0, `indice`=0, `Ban_List`=0, `listo`=0. Reset takes effect immediately and aborts any accumulation in progress. No partial result is published.
- Let E0 be the clock edge at which `start` is sampled in IDLE.
- `Ban_List` rises at E0.
- The product for tap k is added at edge E(2k+2).
- At edge E(2·TAPS+1):
  - `Datos_Sum` updates;
  - `Ban_List` falls;
  - `listo` rises.
- `listo` falls at E(2·TAPS+2).
- Latency from `start` to result is 2·TAPS+1 cycles; with TAPS=5 this is 11.
- Earliest next `start` is sampled at E(2·TAPS+2), which gives a throughput of one result per 2·TAPS+2 cycles.
- All outputs are registered. No combinational path runs from `coef`/`dato`/`start` to any output.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `Datos_Sum`=0, `Ban_List`=0, `listo`=0, `indice`=0. After release with `start`=0, all outputs stay at 0.
- Unity (TAPS=5): all `coef`=`dato`=0x0004000 (1.0); pulse `start` → `indice` steps 0,1,2,3,4 every 2 cycles. `Datos_Sum`=5·2^28=0x50000000 appears 11 cycles after E0, coincident with `Ban_List` 1→0 and a 1-cycle `listo`.
- Signed: `coef`=0x1FFC000 (−1.0), `dato`=0x0002000 (0.5), all taps → `Datos_Sum`=−671088640 as 50-bit two's complement (0x3FFFFD8000000).
- Busy-start ignore: repeat the unity case and re-assert `start` at E0+4 and E0+10 → `indice` sequence, result and 11-cycle latency are unchanged. There is no second run without a new `start` in IDLE.
- Mid-run reset: drop `rst_n` after tap 2 is added → outputs go to 0 at once, `Datos_Sum` stays 0. Then release reset and pulse `start` → correct unity result 0x50000000.
- Wrap-around: `coef`=`dato`=0x1000000 (−1024.0) on all 5 taps. Each product is +2^48, so the sum of 5·2^48 wraps modulo 2^50 → `Datos_Sum`=0x1000000000000 (2^48). `Ban_List` and `listo` timing are the same as in the unity case.
